// File: rtl/s2c_arb_pkg.sv
// Shared types and defaults for the s2c command-channel arbiter.
package s2c_arb_pkg;

  typedef enum logic [0:0] {
    StIdle,
    StBusy
  } state_e;

  localparam int unsigned CntW       = 16;
  localparam int unsigned DefNumReq  = 4;
  localparam int unsigned DefDataW   = 32;
  localparam int unsigned DefTimeout = 255;

endpackage

// File: rtl/s2c_arb_if.sv
// Bundle between the driver requesters (master) and the s2c arbiter (slave).
interface s2c_arb_if
  import s2c_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = DefNumReq,
  parameter int unsigned DATA_W  = DefDataW
);

  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ-1:0]        done;
  logic [NUM_REQ-1:0]        fin;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ-1:0]        grant;
  logic [DATA_W-1:0]         ch_data;
  logic                      ch_valid;
  logic                      ch_ready;
  logic                      timeout_err;
  logic                      all_end;

  modport master (
    output req, done, fin, req_data, req_valid, ch_ready,
    input  req_ready, grant, ch_data, ch_valid, timeout_err, all_end
  );

  modport slave (
    input  req, done, fin, req_data, req_valid, ch_ready,
    output req_ready, grant, ch_data, ch_valid, timeout_err, all_end
  );

endinterface

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request after last_i, wrapping to 0.
module rr_pick #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned IdxW    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IdxW-1:0]    last_i,
  output logic [NUM_REQ-1:0] onehot_o,
  output logic [IdxW-1:0]    idx_o,
  output logic               any_o
);

  always_comb begin
    int unsigned c;
    onehot_o = '0;
    idx_o    = '0;
    any_o    = 1'b0;
    c        = 0;
    // Offset 1..NUM_REQ so last_i itself is the lowest priority.
    for (int unsigned i = 1; i <= NUM_REQ; i++) begin
      c = (32'(last_i) + i) % NUM_REQ;
      if (!any_o && req_i[IdxW'(c)]) begin
        any_o                = 1'b1;
        onehot_o[IdxW'(c)]   = 1'b1;
        idx_o                = IdxW'(c);
      end
    end
  end

endmodule

// File: rtl/s2c_arb.sv
// Round-robin arbiter granting one driver at a time onto the shared s2c command channel.
module s2c_arb
  import s2c_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = DefNumReq,
  parameter int unsigned DATA_W  = DefDataW,
  parameter int unsigned TIMEOUT = DefTimeout
) (
  input logic     clk,
  input logic     rst,
  s2c_arb_if.slave bus
);

  localparam int unsigned IdxW = $clog2(NUM_REQ);

  state_e              state_q, state_d;
  logic [NUM_REQ-1:0]  grant_q, grant_d;
  logic [IdxW-1:0]     gidx_q, gidx_d;
  logic [IdxW-1:0]     last_q, last_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic                tout_q, tout_d;
  logic [NUM_REQ-1:0]  fin_q, fin_d;
  logic                all_end_q, all_end_d;

  logic [NUM_REQ-1:0]  pick_oh;
  logic [IdxW-1:0]     pick_idx;
  logic                pick_any;
  logic [DATA_W-1:0]   ch_data;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IdxW    (IdxW)
  ) u_rr_pick (
    .req_i    (bus.req),
    .last_i   (last_q),
    .onehot_o (pick_oh),
    .idx_o    (pick_idx),
    .any_o    (pick_any)
  );

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    gidx_d    = gidx_q;
    last_d    = last_q;
    cnt_d     = cnt_q;
    tout_d    = 1'b0;
    fin_d     = fin_q | bus.fin;
    all_end_d = all_end_q | (&fin_d);

    unique case (state_q)
      StIdle: begin
        grant_d = '0;
        if (pick_any) begin
          grant_d = pick_oh;
          gidx_d  = pick_idx;
          cnt_d   = '0;
          state_d = StBusy;
        end
      end
      StBusy: begin
        cnt_d = cnt_q + 1'b1;
        // A done on the timeout edge wins, so no error is flagged for it.
        if (bus.done[gidx_q]) begin
          grant_d = '0;
          last_d  = gidx_q;
          state_d = StIdle;
        end else if (cnt_d == CntW'(TIMEOUT)) begin
          grant_d = '0;
          last_d  = gidx_q;
          state_d = StIdle;
          tout_d  = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= StIdle;
      grant_q   <= '0;
      gidx_q    <= '0;
      last_q    <= IdxW'(NUM_REQ - 1);
      cnt_q     <= '0;
      tout_q    <= 1'b0;
      fin_q     <= '0;
      all_end_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      gidx_q    <= gidx_d;
      last_q    <= last_d;
      cnt_q     <= cnt_d;
      tout_q    <= tout_d;
      fin_q     <= fin_d;
      all_end_q <= all_end_d;
    end
  end

  // grant_q is non-zero only in BUSY, so it doubles as the channel mux select.
  always_comb begin
    ch_data = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (grant_q[i]) begin
        ch_data = ch_data | bus.req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  assign bus.ch_data     = ch_data;
  assign bus.ch_valid    = |(grant_q & bus.req_valid);
  assign bus.req_ready   = grant_q & {NUM_REQ{bus.ch_ready}};
  assign bus.grant       = grant_q;
  assign bus.timeout_err = tout_q;
  assign bus.all_end     = all_end_q;

endmodule

// File: tb/tb_s2c_arb.sv
// Directed scoreboard bench for s2c_arb (4 requesters, 32-bit words, timeout of 8).
module tb_s2c_arb;

  localparam int unsigned N  = 4;
  localparam int unsigned W  = 32;
  localparam int unsigned TO = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;

  always #5 clk = ~clk;

  s2c_arb_if #(.NUM_REQ(N), .DATA_W(W)) bus ();

  s2c_arb #(
    .NUM_REQ (N),
    .DATA_W  (W),
    .TIMEOUT (TO)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic push(input string tag, input logic [31:0] val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    sb.push_back(e);
  endtask

  task automatic chk(input logic [31:0] obs);
    exp_t e;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $error("FAIL sb_empty: got %0h, nothing expected", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.val) else begin
        errors++;
        $error("FAIL %s: got %0h required %0h", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bus.req       = '0;
    bus.done      = '0;
    bus.fin       = '0;
    bus.req_data  = '0;
    bus.req_valid = '0;
    bus.ch_ready  = 1'b0;
    rst           = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    push("rst_grant", 0);   chk(32'(bus.grant));
    push("rst_terr", 0);    chk(32'(bus.timeout_err));
    push("rst_all_end", 0); chk(32'(bus.all_end));
    push("rst_chv", 0);     chk(32'(bus.ch_valid));
    push("rst_rdy", 0);     chk(32'(bus.req_ready));
    rst = 1'b1;
    tick();

    // Single requester grant and release.
    bus.req = 4'b0001;
    push("t031_grant", 'b0001);
    tick(); chk(32'(bus.grant));
    bus.done = 4'b0001;
    bus.req  = '0;
    push("t031_release", 0);
    tick(); chk(32'(bus.grant));
    bus.done = '0;

    // Reset so the rotation starts again from requester 0.
    rst = 1'b0;
    #1;
    rst = 1'b1;
    tick();

    // Full rotation with a gap cycle after every release.
    bus.req = '1;
    for (int k = 0; k < 5; k++) begin
      push($sformatf("t032_grant%0d", k), 32'(1 << (k % 4)));
      tick(); chk(32'(bus.grant));
      bus.done = 4'(1 << (k % 4));
      if (k == 4) bus.req = '0;
      push($sformatf("t032_gap%0d", k), 0);
      tick(); chk(32'(bus.grant));
      bus.done = '0;
    end

    // Data path through grant 2, plus ignored done and req drop.
    bus.req = 4'b0100;
    push("t033_grant", 'b0100);
    tick(); chk(32'(bus.grant));
    bus.req_data  = {32'h1111_1111, 32'hDEAD_BEEF, 32'h2222_2222, 32'h3333_3333};
    bus.req_valid = 4'b0100;
    bus.ch_ready  = 1'b1;
    push("t033_data", 32'hDEAD_BEEF);
    push("t033_valid", 1);
    push("t033_ready", 'b0100);
    #1;
    chk(32'(bus.ch_data));
    chk(32'(bus.ch_valid));
    chk(32'(bus.req_ready));
    bus.ch_ready = 1'b0;
    push("t033_ready_low", 0);
    #1; chk(32'(bus.req_ready));
    bus.done = 4'b0001;
    bus.req  = '0;
    push("t033_hold", 'b0100);
    tick(); chk(32'(bus.grant));
    bus.done = 4'b0100;
    push("t033_release", 0);
    tick(); chk(32'(bus.grant));
    bus.done     = '0;
    bus.ch_ready = 1'b1;
    push("t033_idle_data", 0);
    push("t033_idle_valid", 0);
    push("t033_idle_ready", 0);
    #1;
    chk(32'(bus.ch_data));
    chk(32'(bus.ch_valid));
    chk(32'(bus.req_ready));
    bus.req_valid = '0;
    bus.req_data  = '0;
    bus.ch_ready  = 1'b0;

    // Forced release after TO busy cycles.
    bus.req = 4'b1000;
    push("t034_grant", 'b1000);
    tick(); chk(32'(bus.grant));
    bus.req = '0;
    for (int i = 0; i < int'(TO) - 1; i++) begin
      push($sformatf("t034_hold%0d", i), 'b1000);
      push($sformatf("t034_terr%0d", i), 0);
      tick();
      chk(32'(bus.grant));
      chk(32'(bus.timeout_err));
    end
    push("t034_drop", 0);
    push("t034_terr_pulse", 1);
    tick();
    chk(32'(bus.grant));
    chk(32'(bus.timeout_err));
    push("t034_terr_clear", 0);
    tick(); chk(32'(bus.timeout_err));

    // done on the timeout edge is a normal release.
    bus.req = 4'b0001;
    push("t024_grant", 'b0001);
    tick(); chk(32'(bus.grant));
    bus.req = '0;
    repeat (TO - 1) tick();
    bus.done = 4'b0001;
    push("t024_drop", 0);
    push("t024_no_terr", 0);
    tick();
    chk(32'(bus.grant));
    chk(32'(bus.timeout_err));
    bus.done = '0;
    push("t024_no_terr_next", 0);
    tick(); chk(32'(bus.timeout_err));

    // Sticky all_end.
    bus.fin = 4'b0001; tick();
    bus.fin = 4'b0010; tick();
    bus.fin = 4'b0100; tick();
    bus.fin = '0;
    push("t035_low_a", 0); chk(32'(bus.all_end));
    tick();
    push("t035_low_b", 0); chk(32'(bus.all_end));
    bus.fin = 4'b1000;
    tick();
    bus.fin = '0;
    push("t035_high", 1); chk(32'(bus.all_end));
    tick();
    push("t035_sticky", 1); chk(32'(bus.all_end));

    // Asynchronous reset in BUSY, then arbitration restarts from 0.
    bus.req = 4'b0010;
    push("t036_grant", 'b0010);
    tick(); chk(32'(bus.grant));
    rst = 1'b0;
    #1;
    push("t036_async_grant", 0);    chk(32'(bus.grant));
    push("t036_async_terr", 0);     chk(32'(bus.timeout_err));
    push("t036_async_all_end", 0);  chk(32'(bus.all_end));
    tick();
    rst = 1'b1;
    push("t036_regrant", 'b0010);
    tick(); chk(32'(bus.grant));
    push("t036_terr", 0); chk(32'(bus.timeout_err));
    bus.req  = '0;
    bus.done = 4'b0010;
    push("t036_release", 0);
    tick(); chk(32'(bus.grant));
    bus.done = '0;

    // Priority after reset starts at requester 0.
    rst = 1'b0;
    #1;
    rst = 1'b1;
    bus.req = 4'b0011;
    push("rr_from_zero", 'b0001);
    tick(); chk(32'(bus.grant));
    bus.req = '0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
